ps2_byte_rx: RTL and testbench

PS/2 device-to-host byte receiver feeding the keyboard decoder. Synchronises and deglitches the raw PS/2 clock and data lines, and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Outputs each received byte with a one-cycle valid pulse, or a one-cycle error pulse on a malformed or stalled frame. Receive-only; never drives the PS/2 lines.

---
 rtl/ps2_byte_rx.sv | 134 +++++++++++++
 tb/tb_ps2_byte_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host byte receiver: synchronises and deglitches the PS/2 lines,
// deserialises 11-bit frames and reports each byte (valid) or a rejected frame (error).
module ps2_byte_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] filt_sh;
  logic                  filt_clk;
  logic                  fall;
  logic                  s_bit;

  state_t        state, state_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          parity, parity_d;
  logic [TW-1:0] to_cnt, to_cnt_d;
  logic [7:0]    data_d;
  logic          valid_d, error_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt_sh   <= '1;
      filt_clk  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_sh   <= {filt_sh[FILTER_LEN-2:0], clk_sync[1]};
      if (filt_sh == '0)      filt_clk <= 1'b0;
      else if (filt_sh == '1) filt_clk <= 1'b1;
    end
  end

  // Falling edge of the filtered clock, seen in the cycle the filter flips.
  assign fall  = filt_clk && (filt_sh == '0);
  assign s_bit = data_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      to_cnt  <= '0;
      data    <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      parity  <= parity_d;
      to_cnt  <= to_cnt_d;
      data    <= data_d;
      valid   <= valid_d;
      error   <= error_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    parity_d  = parity;
    data_d    = data;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    if (fall || state == IDLE)                to_cnt_d = '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))   to_cnt_d = to_cnt + TW'(1);
    else                                      to_cnt_d = to_cnt;

    case (state)
      IDLE: begin
        if (fall && !s_bit) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_d[bit_cnt] = s_bit;
          bit_cnt_d        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = s_bit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (s_bit && (^{shreg, parity})) begin
            data_d  = shreg;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; a sample event in the same cycle wins.
    if (!fall && state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      error_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Self-checking bench for ps2_byte_rx: table vectors, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_ps2_byte_rx;

  localparam int FLEN = 8;
  localparam int TOUT = 1200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       error;

  ps2_byte_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .valid(valid), .error(error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int ecnt  = 0;
  int both  = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt++;
      got_q.push_back(data);
    end
    if (error === 1'b1) ecnt++;
    if (valid === 1'b1 && error === 1'b1) both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drives start + the first n_bits of frame_bits (LSB first) as a PS/2 device would.
  task automatic send_bits(input logic [10:0] frame_bits, input int n_bits, input int half);
    for (int i = 0; i < n_bits; i++) begin
      ps2_data = frame_bits[i];
      wait_cycles(half);
      ps2_clk = 1'b0;
      wait_cycles(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_bad,
                                             input logic stop);
    logic par;
    par = ~(^b) ^ par_bad;  // odd parity over data + parity
    return {stop, par, b, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       par_bad;
    logic       stop;
    int         half;
    int         exp_valid;
    int         exp_error;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] last_good;

  initial begin
    int v0, e0;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 500, 1, 0, 8'h1C};
    vecs[1] = '{8'h29, 1'b1, 1'b1, 40,  0, 1, 8'h1C};
    vecs[2] = '{8'h29, 1'b0, 1'b0, 40,  0, 1, 8'h1C};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 30,  1, 0, 8'hA5};

    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_error", 32'(error), 32'h0);
    rst_n = 1'b1;
    wait_cycles(20);

    foreach (vecs[i]) begin
      v0 = vcnt; e0 = ecnt;
      send_bits(make_frame(vecs[i].b, vecs[i].par_bad, vecs[i].stop), 11, vecs[i].half);
      wait_cycles(20);
      check($sformatf("vec%0d_valid_n", i), 32'(vcnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_error_n", i), 32'(ecnt - e0), 32'(vecs[i].exp_error));
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
    end
    last_good = 8'hA5;

    // Back-to-back frames with no idle gap.
    v0 = vcnt; e0 = ecnt;
    send_bits(make_frame(8'hE0, 1'b0, 1'b1), 11, 40);
    send_bits(make_frame(8'h75, 1'b0, 1'b1), 11, 40);
    wait_cycles(20);
    check("b2b_valid_n", 32'(vcnt - v0), 32'd2);
    check("b2b_error_n", 32'(ecnt - e0), 32'd0);
    if (got_q.size() >= 2) begin
      check("b2b_first", 32'(got_q[got_q.size()-2]), 32'hE0);
      check("b2b_second", 32'(got_q[got_q.size()-1]), 32'h75);
    end else begin
      check("b2b_queue_len", 32'(got_q.size()), 32'd2);
    end
    last_good = 8'h75;

    // Short clock glitch with data low must not start a frame.
    v0 = vcnt; e0 = ecnt;
    ps2_data = 1'b0;
    wait_cycles(20);
    ps2_clk = 1'b0;
    wait_cycles(5);
    ps2_clk = 1'b1;
    wait_cycles(20);
    ps2_data = 1'b1;
    wait_cycles(20);
    check("glitch_pulses", 32'(vcnt - v0 + ecnt - e0), 32'd0);
    send_bits(make_frame(8'h05, 1'b0, 1'b1), 11, 40);
    wait_cycles(20);
    check("glitch_valid_n", 32'(vcnt - v0), 32'd1);
    check("glitch_error_n", 32'(ecnt - e0), 32'd0);
    check("glitch_data", 32'(data), 32'h05);

    // Stall after 4 data bits: no early abort, then exactly one error.
    v0 = vcnt; e0 = ecnt;
    send_bits(make_frame(8'h33, 1'b0, 1'b1), 5, 40);
    wait_cycles(TOUT - 100);
    check("timeout_early", 32'(ecnt - e0), 32'd0);
    wait_cycles(110);
    check("timeout_error_n", 32'(ecnt - e0), 32'd1);
    check("timeout_valid_n", 32'(vcnt - v0), 32'd0);
    check("timeout_data", 32'(data), 32'h05);
    send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11, 40);
    wait_cycles(20);
    check("post_timeout_valid_n", 32'(vcnt - v0), 32'd1);
    check("post_timeout_data", 32'(data), 32'hF0);

    // Reset mid-frame after the 6th data bit.
    v0 = vcnt; e0 = ecnt;
    send_bits(make_frame(8'h5A, 1'b0, 1'b1), 7, 40);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_outs", i), {22'd0, valid, error, data}, 32'h0);
    end
    rst_n = 1'b1;
    wait_cycles(TOUT + 20);
    check("rst_no_pulse", 32'(vcnt - v0 + ecnt - e0), 32'd0);
    send_bits(make_frame(8'h66, 1'b0, 1'b1), 11, 40);
    wait_cycles(20);
    check("post_rst_valid_n", 32'(vcnt - v0), 32'd1);
    check("post_rst_data", 32'(data), 32'h66);
    last_good = 8'h66;

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 10; i++) begin
      logic [7:0]  b;
      logic [10:0] f;
      int          mode, half;
      logic        ok;
      b    = 8'($urandom);
      mode = $urandom_range(0, 3);
      half = $urandom_range(20, 60);
      f    = make_frame(b, mode == 2, mode != 3);
      ok   = (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
      if (ok) last_good = b;
      v0 = vcnt; e0 = ecnt;
      send_bits(f, 11, half);
      wait_cycles(20);
      check($sformatf("rnd%0d_valid_n", i), 32'(vcnt - v0), ok ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_error_n", i), 32'(ecnt - e0), ok ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_data", i), 32'(data), 32'(last_good));
    end

    check("valid_error_overlap", 32'(both), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
